// File: rtl/tick_pkg.sv
// rtl/tick_pkg.sv - shared constants and helpers for the tick scheduler
package tick_pkg;

  localparam int DEF_PRE_DIV = 100000;
  localparam int DEF_NCH     = 4;
  localparam int DEF_CNT_W   = 16;
  localparam int DEF_BASE_W  = 26;

  typedef enum logic {
    MODE_PERIODIC = 1'b0,
    MODE_ONESHOT  = 1'b1
  } tick_mode_e;

  // Channel select needs at least one bit even for a single channel.
  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tick_scheduler_if.sv
// rtl/tick_scheduler_if.sv - channel configuration load bus
interface tick_scheduler_if
  import tick_pkg::*;
#(
  parameter int NCH   = DEF_NCH,
  parameter int CNT_W = DEF_CNT_W
);

  localparam int CH_W = ch_w(NCH);

  logic             ld_valid;
  logic [CH_W-1:0]  ld_ch;
  logic [CNT_W-1:0] ld_div;
  logic             ld_mode;

  modport master (
    output ld_valid,
    output ld_ch,
    output ld_div,
    output ld_mode
  );

  modport slave (
    input ld_valid,
    input ld_ch,
    input ld_div,
    input ld_mode
  );

endinterface

// File: rtl/tick_channel.sv
// rtl/tick_channel.sv - one divided tick channel: divisor/mode registers, counter, pulse
module tick_channel
  import tick_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             step,
  input  logic             ld_sel,
  input  logic [CNT_W-1:0] ld_div,
  input  logic             ld_mode,
  output logic             tick,
  output logic             busy
);

  logic [CNT_W-1:0] div;
  logic [CNT_W-1:0] cnt;
  tick_mode_e       mode;
  logic             spent;

  // A spent one-shot drops busy on the same edge that raises its tick.
  assign busy = (div != '0) && !spent;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div   <= '0;
      cnt   <= '0;
      mode  <= MODE_PERIODIC;
      spent <= 1'b0;
      tick  <= 1'b0;
    end else if (clr) begin
      cnt   <= '0;
      spent <= 1'b0;
      tick  <= 1'b0;
    end else if (ld_sel) begin
      div   <= ld_div;
      mode  <= tick_mode_e'(ld_mode);
      cnt   <= '0;
      spent <= 1'b0;
      tick  <= 1'b0;
    end else begin
      tick <= 1'b0;
      if (step && busy) begin
        if (cnt == div - 1'b1) begin
          cnt  <= '0;
          tick <= 1'b1;
          if (mode == MODE_ONESHOT) begin
            spent <= 1'b1;
          end
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/tick_scheduler.sv
// rtl/tick_scheduler.sv - prescaled base tick, base tick counter and NCH divided tick channels
module tick_scheduler
  import tick_pkg::*;
#(
  parameter int PRE_DIV = DEF_PRE_DIV,
  parameter int NCH     = DEF_NCH,
  parameter int CNT_W   = DEF_CNT_W,
  parameter int BASE_W  = DEF_BASE_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              clr,
  tick_scheduler_if.slave   ld,
  output logic              base_tick,
  output logic [BASE_W-1:0] base_cnt,
  output logic [NCH-1:0]    tick,
  output logic [NCH-1:0]    busy
);

  localparam int CH_W  = ch_w(NCH);
  localparam int PRE_W = $clog2(PRE_DIV);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRE_DIV - 1);

  if (PRE_DIV < 2) begin : g_bad_pre_div
    $error("tick_scheduler: PRE_DIV must be >= 2");
  end
  if (NCH < 1 || NCH > 16) begin : g_bad_nch
    $error("tick_scheduler: NCH must be 1..16");
  end

  logic [PRE_W-1:0] pre;
  logic             adv;

  // adv marks the edge on which a base tick is issued; channels step on it too.
  assign adv = en && (pre == PRE_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre       <= '0;
      base_tick <= 1'b0;
      base_cnt  <= '0;
    end else if (clr) begin
      pre       <= '0;
      base_tick <= 1'b0;
      base_cnt  <= '0;
    end else begin
      base_tick <= adv;
      if (en) begin
        pre <= adv ? '0 : pre + 1'b1;
      end
      if (adv) begin
        base_cnt <= base_cnt + 1'b1;
      end
    end
  end

  // Out-of-range ld_ch matches no channel index, so such loads are dropped.
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    tick_channel #(
      .CNT_W (CNT_W)
    ) u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (clr),
      .step    (adv),
      .ld_sel  (ld.ld_valid && (ld.ld_ch == CH_W'(i))),
      .ld_div  (ld.ld_div),
      .ld_mode (ld.ld_mode),
      .tick    (tick[i]),
      .busy    (busy[i])
    );
  end

endmodule
